ssm_funnel_shifter: RTL
=======================

Name: ssm_funnel_shifter

Overview:
- Parametrised substream funnel shifter for the VDC-M bit parser; next generation of the fixed 128-bit per-substream shifter.
- Accepts fixed-width bitstream words through a valid/ready handshake and presents an MSB-aligned peek window to the block-level syntax decoders.
- Retires a variable number of bits per cycle as reported by the decoders (MPP suffix, XFM coefficients, BP).
- One instance per substream; widths are generic, with overflow/underflow protection and a synchronous flush for slice boundaries.

Parameters:
- IN_W, 128, width of one input bitstream word in bits.
- PEEK_W, 128, width of the peek window and maximum bits consumable per cycle.
- BUF_W, 256, shifter storage in bits. Must satisfy BUF_W >= IN_W + PEEK_W - 1; elaboration fails otherwise.
- CNT_W, $clog2(BUF_W+1), width of the fullness count (derived; do not override).
- CB_W, $clog2(PEEK_W+1), width of consume_bits (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear of buffer, fullness and error.
- in_data  in  IN_W  bitstream word, MSB is the earliest bit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  word is accepted when in_valid && in_ready.
- peek_data  out  PEEK_W  next PEEK_W unconsumed bits, MSB-aligned; unfilled LSBs read 0.
- peek_valid  out  1  fullness >= PEEK_W.
- consume_en  in  1  retire consume_bits this cycle.
- consume_bits  in  CB_W  number of bits to retire, 0..PEEK_W.
- fullness  out  CNT_W  valid bits currently held.
- underflow_err  out  1  sticky illegal-consume flag.

Behaviour:
- Storage: BUF_W-bit register `buf`, MSB-first. Valid bits occupy buf[BUF_W-1 -: fullness]; all bits below the valid region are 0 at all times.
- Reset (rst high, asynchronous): buf = 0, fullness = 0, underflow_err = 0. Resulting outputs: peek_data = 0, peek_valid = 0, in_ready = 1. Reset may arrive mid-operation; partially consumed data is discarded.
- in_ready = !flush && (fullness <= BUF_W - IN_W). It depends only on registered state, with no combinational path from consume_en.
- Consume legality: legal = consume_en && consume_bits <= fullness && consume_bits <= PEEK_W.
  - Effective consume c = legal ? consume_bits : 0.
  - An illegal request retires nothing, sets underflow_err next cycle, and underflow_err stays set until flush or rst.
- Write: w = in_valid && in_ready.
- Per-cycle update, when flush is low:
  - buf_next = (buf << c) | (w ? in_data << (BUF_W - IN_W - (fullness - c)) : 0).
  - fullness_next = fullness - c + (w ? IN_W : 0).
  - Simultaneous write and consume in one cycle is required. The new word lands immediately after the bits that remain post-consume.
- Capacity bound: fullness never exceeds BUF_W. Worst case is fullness = BUF_W - IN_W with a write and no consume, giving exactly BUF_W.
- Latency: a word accepted in cycle N is visible on peek_data/fullness in cycle N+1. A consume in cycle N is reflected in cycle N+1. peek_data is a direct slice buf[BUF_W-1 -: PEEK_W], with no extra register.
- Decoder handoff:
  - peek_valid gates normal decoding.
  - Consume is permitted with peek_valid low as long as consume_bits <= fullness; this covers end of slice.
  - consume_bits = 0 with consume_en high is legal and is a no-op.
- Flush: synchronous and has priority over write and consume in the same cycle. Next cycle: buf = 0, fullness = 0, underflow_err = 0. in_valid is not accepted during the flush cycle.
- Empty: fullness = 0 gives peek_data = 0. Any consume_bits > 0 in this state is illegal (underflow_err).

Optional Feature:
- Macro: SSM_BITCNT_EN.
- Defined:
  - Adds output consumed_total [31:0], the running sum of effective c.
  - Reset value 0; cleared by flush; wraps modulo 2^32.
  - Used by rate control to cross-check per-block bit budgets.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset check: assert rst, release. Required: fullness=0, in_ready=1, peek_valid=0, peek_data=0, underflow_err=0.
2. First word: write W0=128'h0123456789ABCDEFFEDCBA9876543210. Next cycle: fullness=128, peek_valid=1, peek_data=W0.
3. Consume with write in same cycle: fullness=128; consume 4 and write W1=128'hFFFF...F. Next cycle: fullness=252, peek_data = {W0[123:0], 4'hF}.
4. Backpressure: at fullness=252, in_ready=0 and a held in_valid is not accepted. Consume 128. Next cycle: fullness=124, in_ready=1. The held word is accepted and fullness=252 the following cycle.
5. Illegal consume:
   - At fullness=4, consume 10: fullness stays 4, underflow_err=1 and stays 1.
   - Then flush: fullness=0, underflow_err=0.
6. Reset mid-stream, and bit count:
   - rst pulse at fullness=200: all outputs return to reset values immediately (asynchronously).
   - With SSM_BITCNT_EN defined: consume 4, 7, 117, then consumed_total=128; flush returns it to 0.

Source files
------------

// File: rtl/ssm_funnel_shifter.sv
// Substream funnel shifter: MSB-aligned bit buffer with word push and variable-width consume.
// Optional macro SSM_BITCNT_EN adds the consumed_total running bit counter.
module ssm_funnel_shifter #(
    parameter int IN_W   = 128,
    parameter int PEEK_W = 128,
    parameter int BUF_W  = 256,
    parameter int CNT_W  = $clog2(BUF_W + 1),
    parameter int CB_W   = $clog2(PEEK_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PEEK_W-1:0] peek_data,
    output logic              peek_valid,
    input  logic              consume_en,
    input  logic [CB_W-1:0]   consume_bits,
    output logic [CNT_W-1:0]  fullness,
    output logic              underflow_err
`ifdef SSM_BITCNT_EN
    ,
    output logic [31:0]       consumed_total
`endif
);

    generate
        if (BUF_W < IN_W + PEEK_W - 1) begin : g_bad_size
            $fatal(1, "ssm_funnel_shifter: BUF_W must be >= IN_W + PEEK_W - 1");
        end
    endgenerate

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_full;
    logic             r_err;

    logic [CNT_W-1:0] w_cb;
    logic             w_legal;
    logic             w_illegal;
    logic [CNT_W-1:0] w_c;
    logic             w_wr;
    logic [CNT_W-1:0] w_remain;
    logic [BUF_W-1:0] w_ins;
    logic [BUF_W-1:0] w_buf_next;
    logic [CNT_W-1:0] w_full_next;

    assign w_cb      = CNT_W'(consume_bits);
    assign w_legal   = consume_en && (w_cb <= r_full) && (w_cb <= CNT_W'(PEEK_W));
    assign w_illegal = consume_en && !w_legal;
    assign w_c       = w_legal ? w_cb : '0;

    // Readiness looks only at registered fullness, never at the consume request.
    assign in_ready  = !flush && (r_full <= CNT_W'(BUF_W - IN_W));
    assign w_wr      = in_valid && in_ready;

    // The new word lands directly behind whatever survives this cycle's consume.
    assign w_remain    = r_full - w_c;
    assign w_ins       = (BUF_W'(in_data) << (BUF_W - IN_W)) >> w_remain;
    assign w_buf_next  = (r_buf << w_c) | (w_wr ? w_ins : '0);
    assign w_full_next = w_remain + (w_wr ? CNT_W'(IN_W) : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf  <= '0;
            r_full <= '0;
            r_err  <= 1'b0;
        end else if (flush) begin
            r_buf  <= '0;
            r_full <= '0;
            r_err  <= 1'b0;
        end else begin
            r_buf  <= w_buf_next;
            r_full <= w_full_next;
            if (w_illegal)
                r_err <= 1'b1;
        end
    end

`ifdef SSM_BITCNT_EN
    logic [31:0] r_total;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_total <= '0;
        else if (flush)
            r_total <= '0;
        else
            r_total <= r_total + 32'(w_c);
    end

    assign consumed_total = r_total;
`endif

    assign peek_data     = r_buf[BUF_W-1 -: PEEK_W];
    assign peek_valid    = (r_full >= CNT_W'(PEEK_W));
    assign fullness      = r_full;
    assign underflow_err = r_err;

endmodule
